// File: rtl/tmr_voter_reg.sv
// Registered triple-modular-redundancy voter with per-lane error flags, sticky flags and counters.
// Define TMR_VOTER_CNT_EN to build in the saturating per-lane error counters.

module tmr_lane_mon #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_hit,
    output logic                 o_sticky,
    output logic [CNT_WIDTH-1:0] o_cnt
);
    logic r_sticky;

    // clr wipes history, but a hit in the same cycle is still recorded
    always_ff @(posedge clk) begin
        if (rst)
            r_sticky <= 1'b0;
        else if (i_clr)
            r_sticky <= i_hit;
        else if (i_hit)
            r_sticky <= 1'b1;
    end

    assign o_sticky = r_sticky;

`ifdef TMR_VOTER_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= i_hit ? CNT_WIDTH'(1) : '0;
        else if (i_hit && (r_cnt != CNT_MAX))
            r_cnt <= r_cnt + CNT_WIDTH'(1);
    end

    assign o_cnt = r_cnt;
`else
    assign o_cnt = '0;
`endif
endmodule

module tmr_voter_reg #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     inA,
    input  logic [WIDTH-1:0]     inB,
    input  logic [WIDTH-1:0]     inC,
    input  logic                 clr,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    output logic [2:0]           lane_err,
    output logic                 multi_err,
    output logic [2:0]           sticky_err,
    output logic [CNT_WIDTH-1:0] cnt_a,
    output logic [CNT_WIDTH-1:0] cnt_b,
    output logic [CNT_WIDTH-1:0] cnt_c
);
    logic [WIDTH-1:0]               w_voted;
    logic [2:0]                     w_err;
    logic [2:0]                     w_hit;
    logic                           w_multi;
    logic [2:0][CNT_WIDTH-1:0]      w_cnt;

    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic [2:0]       r_lane_err;
    logic             r_multi_err;

    assign w_voted = (inA & inB) | (inA & inC) | (inB & inC);
    assign w_err   = {|(inC ^ w_voted), |(inB ^ w_voted), |(inA ^ w_voted)};
    assign w_multi = (w_err[0] & w_err[1]) | (w_err[0] & w_err[2]) | (w_err[1] & w_err[2]);
    assign w_hit   = w_err & {3{in_valid}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_lane_err  <= '0;
            r_multi_err <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            r_lane_err  <= w_hit;
            r_multi_err <= in_valid & w_multi;
            if (in_valid)
                r_out <= w_voted;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_lane
        tmr_lane_mon #(.CNT_WIDTH(CNT_WIDTH)) u_mon (
            .clk      (clk),
            .rst      (rst),
            .i_clr    (clr),
            .i_hit    (w_hit[g]),
            .o_sticky (sticky_err[g]),
            .o_cnt    (w_cnt[g])
        );
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign lane_err  = r_lane_err;
    assign multi_err = r_multi_err;
    assign cnt_a     = w_cnt[0];
    assign cnt_b     = w_cnt[1];
    assign cnt_c     = w_cnt[2];
endmodule

// File: tb/tb_tmr_voter_reg.sv
// Directed table-driven bench for tmr_voter_reg (WIDTH=8, CNT_WIDTH=4); counter
// expectations collapse to zero when TMR_VOTER_CNT_EN is not defined.
module tb_tmr_voter_reg;
    localparam int W  = 8;
    localparam int CW = 4;
`ifdef TMR_VOTER_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, in_valid, clr;
    logic [W-1:0]  inA, inB, inC;
    logic [W-1:0]  out;
    logic          out_valid, multi_err;
    logic [2:0]    lane_err, sticky_err;
    logic [CW-1:0] cnt_a, cnt_b, cnt_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tmr_voter_reg #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .inA(inA), .inB(inB), .inC(inC), .clr(clr),
        .out(out), .out_valid(out_valid), .lane_err(lane_err),
        .multi_err(multi_err), .sticky_err(sticky_err),
        .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c)
    );

    typedef struct {
        logic         v;
        logic [W-1:0] a, b, c;
        logic         cl;
        logic [W-1:0] eo;
        logic         eov;
        logic [2:0]   ele;
        logic         eme;
        logic [2:0]   est;
        logic [CW-1:0] eca, ecb, ecc;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_cnt(input string nm, input logic [CW-1:0] ea, input logic [CW-1:0] eb,
                           input logic [CW-1:0] ec);
        chk({nm, ".cnt_a"}, 32'(cnt_a), CNT_EN ? 32'(ea) : 32'd0);
        chk({nm, ".cnt_b"}, 32'(cnt_b), CNT_EN ? 32'(eb) : 32'd0);
        chk({nm, ".cnt_c"}, 32'(cnt_c), CNT_EN ? 32'(ec) : 32'd0);
    endtask

    task automatic chk_all(input string nm, input logic [W-1:0] eo, input logic eov,
                           input logic [2:0] ele, input logic eme, input logic [2:0] est,
                           input logic [CW-1:0] ea, input logic [CW-1:0] eb, input logic [CW-1:0] ec);
        chk({nm, ".out"},        32'(out),        32'(eo));
        chk({nm, ".out_valid"},  32'(out_valid),  32'(eov));
        chk({nm, ".lane_err"},   32'(lane_err),   32'(ele));
        chk({nm, ".multi_err"},  32'(multi_err),  32'(eme));
        chk({nm, ".sticky_err"}, 32'(sticky_err), 32'(est));
        chk_cnt(nm, ea, eb, ec);
    endtask

    // Apply inputs just after an edge, clock once, then sample 1 time unit later.
    task automatic step(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic cl);
        rst = r; in_valid = v; inA = a; inB = b; inC = c; clr = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; clr = 1'b0; inA = '0; inB = '0; inC = '0;

        //          v  a      b      c      cl  eo     eov ele     eme  est     ca cb cc
        tbl[0] = '{1'b1, 8'h5A, 8'h5A, 8'h5A, 1'b0, 8'h5A, 1'b1, 3'b000, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0};
        tbl[1] = '{1'b1, 8'h5B, 8'h5A, 8'h5A, 1'b0, 8'h5A, 1'b1, 3'b001, 1'b0, 3'b001, 4'd1, 4'd0, 4'd0};
        tbl[2] = '{1'b1, 8'h01, 8'h02, 8'h04, 1'b0, 8'h00, 1'b1, 3'b111, 1'b1, 3'b111, 4'd2, 4'd1, 4'd1};
        tbl[3] = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 3'b111, 4'd2, 4'd1, 4'd1};
        tbl[4] = '{1'b1, 8'h33, 8'h33, 8'h33, 1'b1, 8'h33, 1'b1, 3'b000, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0};
        tbl[5] = '{1'b1, 8'h33, 8'h30, 8'h33, 1'b0, 8'h33, 1'b1, 3'b010, 1'b0, 3'b010, 4'd0, 4'd1, 4'd0};
        tbl[6] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h33, 1'b0, 3'b000, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0};
        tbl[7] = '{1'b1, 8'h0F, 8'h0E, 8'h1F, 1'b0, 8'h0F, 1'b1, 3'b110, 1'b1, 3'b110, 4'd0, 4'd1, 4'd1};

        // Reset with a sample presented: it must be discarded.
        step(1'b1, 1'b1, 8'hAA, 8'hAA, 8'hAA, 1'b1);
        step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk_all("reset", 8'h00, 1'b0, 3'b000, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0);

        for (int i = 0; i < 8; i++) begin
            step(1'b0, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].cl);
            chk_all($sformatf("vec%0d", i), tbl[i].eo, tbl[i].eov, tbl[i].ele, tbl[i].eme,
                    tbl[i].est, tbl[i].eca, tbl[i].ecb, tbl[i].ecc);
        end

        // Lane B faulted for 20 samples: counter saturates at 15.
        step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        chk_cnt("sat_clr", 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 8'h11, 8'h10, 8'h11, 1'b0);
            chk($sformatf("sat%0d.cnt_b", i), 32'(cnt_b), CNT_EN ? ((i + 1 > 15) ? 32'd15 : 32'(i + 1)) : 32'd0);
            chk($sformatf("sat%0d.out", i), 32'(out), 32'h11);
        end
        chk_all("sat_end", 8'h11, 1'b1, 3'b010, 1'b0, 3'b010, 4'd0, 4'd15, 4'd0);

        // Lane C faulted 7 times, then clr coincident with another C fault.
        step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++)
            step(1'b0, 1'b1, 8'h22, 8'h22, 8'h20, 1'b0);
        chk_all("c7", 8'h22, 1'b1, 3'b100, 1'b0, 3'b100, 4'd0, 4'd0, 4'd7);
        step(1'b0, 1'b1, 8'h22, 8'h22, 8'h20, 1'b1);
        chk_all("clr_hit", 8'h22, 1'b1, 3'b100, 1'b0, 3'b100, 4'd0, 4'd0, 4'd1);

        // Build up cnt_a=5 with out=0x33, then reset mid-stream.
        step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 8'h00, 8'h33, 8'h33, 1'b0);
        chk_all("a5", 8'h33, 1'b1, 3'b001, 1'b0, 3'b001, 4'd5, 4'd0, 4'd0);
        step(1'b1, 1'b1, 8'h77, 8'h70, 8'h77, 1'b0);
        chk_all("mid_rst", 8'h00, 1'b0, 3'b000, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0);
        step(1'b0, 1'b1, 8'h44, 8'h44, 8'h45, 1'b0);
        chk_all("post_rst", 8'h44, 1'b1, 3'b100, 1'b0, 3'b100, 4'd0, 4'd0, 4'd1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk_all("post_idle", 8'h44, 1'b0, 3'b000, 1'b0, 3'b100, 4'd0, 4'd0, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tmr_voter_reg.md
TMR_VOTER_REG -- requirements
Module: tmr_voter_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data width of each replicated lane.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of each per-lane error counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  lanes A/B/C carry a sample this cycle.
REQ-006 SHALL have ports inA, inB, inC  input  WIDTH  triplicated copies of one signal, as driven by the fanout stage.
REQ-007 SHALL have port clr  input  1  single-cycle pulse; clears sticky flags and counters.
REQ-008 SHALL have port out  output  WIDTH  registered bitwise 2-of-3 majority.
REQ-009 SHALL have port out_valid  output  1  out updated this cycle.
REQ-010 SHALL have port lane_err  output  3  registered per-sample flags; bit0=A, bit1=B, bit2=C; lane differs from voted value in any bit.
REQ-011 SHALL have port multi_err  output  1  registered; two or more lane_err bits set for the same sample.
REQ-012 SHALL have port sticky_err  output  3  per-lane sticky OR of lane_err since last rst/clr.
REQ-013 SHALL have ports cnt_a, cnt_b, cnt_c  output  CNT_WIDTH  per-lane error sample counts.

Function
REQ-014 SHALL compute voted = (inA&inB)|(inA&inC)|(inB&inC) per bit.
REQ-015 SHALL, when in_valid=1, register voted into out, set out_valid=1, and register lane_err/multi_err for that sample; latency exactly 1 cycle.
REQ-016 SHALL, when in_valid=0, hold out at its last value and drive out_valid=0, lane_err=0, multi_err=0 next cycle.
REQ-017 SHALL set sticky_err[i] the cycle after any valid sample with lane i in error; hold until rst or clr.
REQ-018 SHALL increment cnt_x by 1 per valid sample with lane x in error (one increment per sample regardless of number of differing bits).
REQ-019 SHALL saturate each counter at 2^CNT_WIDTH-1; no wrap-around.
REQ-020 SHALL, on clr coincident with a valid erroneous sample, clear first then record that sample: sticky bit=1, counter=1.
REQ-021 SHALL, on clr with no error, set all sticky_err=0 and counters=0 next cycle; out/out_valid unaffected.
REQ-022 SHALL treat all-lanes-differ bit patterns by bitwise majority only; multi_err flags it, no other exception.

Reset
REQ-023 SHALL on rst=1 at a clock edge set out=0, out_valid=0, lane_err=0, multi_err=0, sticky_err=0, all counters=0.
REQ-024 SHALL give rst priority over in_valid and clr; a sample presented during rst is discarded.
REQ-025 SHALL resume normal operation on the first edge with rst=0; no extra warm-up cycle.

Configuration
REQ-026 SHALL use macro TMR_VOTER_CNT_EN to compile the per-lane counters in or out.
REQ-027 SHALL, with TMR_VOTER_CNT_EN defined, implement REQ-018..REQ-021 counter behaviour.
REQ-028 SHALL, without TMR_VOTER_CNT_EN, keep ports cnt_a/cnt_b/cnt_c and tie them to constant 0; no counter flops; all other behaviour identical.

Verification (WIDTH=8, CNT_WIDTH=4, TMR_VOTER_CNT_EN defined unless stated)
REQ-029 SHALL cover: in_valid=1, inA=inB=inC=0x5A -> next cycle out=0x5A, out_valid=1, lane_err=000, counters unchanged.
REQ-030 SHALL cover: inA=0x5B, inB=inC=0x5A valid -> out=0x5A, lane_err=001, sticky_err=001, cnt_a=1; with inA=0x01, inB=0x02, inC=0x04 -> out=0x00, lane_err=111, multi_err=1.
REQ-031 SHALL cover: 20 consecutive valid samples with lane B faulted -> cnt_b saturates at 15, stays 15; cnt_a=cnt_c=0.
REQ-032 SHALL cover: clr pulse with lane C faulted in same cycle, prior cnt_c=7 -> cnt_c=1, sticky_err=100.
REQ-033 SHALL cover: rst asserted mid-stream with cnt_a=5, out=0x33 -> next cycle all outputs 0; first valid sample after release appears 1 cycle later.
REQ-034 SHALL cover: build without TMR_VOTER_CNT_EN, lane A faulted 3 samples -> cnt_a=cnt_b=cnt_c=0, sticky_err=001, voting unchanged.
